hero_write_rx: RTL and testbench



---
 rtl/hero_write_rx.sv | 212 +++++++++++++++++++++
 tb/tb_hero_write_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hero_write_rx.sv
// Receive endpoint for the hero write bus.
// Incoming beats are framed into DONE-terminated transactions and stored in a beat FIFO.
// The FIFO is drained by a valid/ready consumer.
// The hero bus cannot be stalled. A VALID beat is therefore admitted only while two
// FIFO slots are free, so that an open transaction can always be closed with a terminator.
//
// Downstream handshake: out_valid is high whenever the FIFO holds a beat. A beat
// transfers on any rising edge where out_valid && out_ready. The head fields stay
// unchanged until that transfer happens. The head fields read as 0 while out_valid is low.
`timescale 1ns/1ps
module hero_write_rx #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [45:0] hero_write,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [35:0] out_wdat,
    output logic [6:0]  out_sub,
    output logic        out_last,
    output logic        out_err,
    input  logic        clr_sticky,
    output logic        ovf_err,
    output logic        proto_err,
    output logic [15:0] txn_cnt,
    output logic [1:0]  dbg_state_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] CT_VALID = 2'd1;
    localparam logic [1:0] CT_DONE  = 2'd2;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_BURST = 2'd1,
        RX_DROP  = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [35:0] wdat;
        logic [6:0]  sub;
        logic        last;
        logic        err;
    } entry_t;

    rx_state_e     state_q, state_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CW-1:0] beat_nxt;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]   occ, free;
    logic          ovf_q, proto_q;
    logic [15:0]   txn_cnt_q;
    entry_t        mem_q [DEPTH];

    logic          push_en;
    entry_t        push_ent;
    logic          set_ovf, set_proto, txn_inc;
    logic          full, empty, pop_en;
    logic [1:0]    ct;
    logic          live;
    entry_t        beat_ent, term_ent, head;

    assign ct       = hero_write[45:44];
    assign live     = hero_write[0] && (ct != 2'd0);
    assign beat_ent = '{wdat: hero_write[43:8], sub: hero_write[7:1], last: 1'b0, err: 1'b0};
    assign term_ent = '{wdat: 36'd0, sub: 7'd0, last: 1'b1, err: 1'b1};

    // Pointers carry one extra wrap bit. Equal low bits with differing MSBs means full.
    assign occ    = wr_ptr_q - rd_ptr_q;
    assign free   = (AW+1)'(DEPTH) - occ;
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_en = !empty && out_ready;
    assign head   = mem_q[rd_ptr_q[AW-1:0]];

    assign out_valid   = !empty;
    assign out_wdat    = out_valid ? head.wdat : 36'd0;
    assign out_sub     = out_valid ? head.sub  : 7'd0;
    assign out_last    = out_valid && head.last;
    assign out_err     = out_valid && head.err;
    assign ovf_err     = ovf_q;
    assign proto_err   = proto_q;
    assign txn_cnt     = txn_cnt_q;
    assign dbg_state_o = state_q;

    // Framing decisions: what to push, which flags to raise, and the next state.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        push_en    = 1'b0;
        push_ent   = beat_ent;
        set_ovf    = 1'b0;
        set_proto  = 1'b0;
        txn_inc    = 1'b0;
        beat_nxt   = beat_cnt_q + CW'(1);
        case (state_q)
            RX_IDLE, RX_BURST: begin
                if (live) begin
                    case (ct)
                        CT_VALID: begin
                            if (beat_nxt == CW'(MAX_BEATS) && free >= (AW+1)'(1)) begin
                                // Over-length: this beat closes the transaction as faulted.
                                push_en       = 1'b1;
                                push_ent.last = 1'b1;
                                push_ent.err  = 1'b1;
                                set_proto     = 1'b1;
                                txn_inc       = 1'b1;
                                beat_cnt_d    = '0;
                                state_d       = RX_DROP;
                            end else if (free < (AW+1)'(2)) begin
                                // No room to admit it and still close later.
                                set_ovf    = 1'b1;
                                beat_cnt_d = '0;
                                state_d    = RX_DROP;
                                if (state_q == RX_BURST) begin
                                    push_en  = 1'b1;
                                    push_ent = term_ent;
                                    txn_inc  = 1'b1;
                                end
                            end else begin
                                push_en    = 1'b1;
                                beat_cnt_d = beat_nxt;
                                state_d    = RX_BURST;
                            end
                        end
                        CT_DONE: begin
                            if (free >= (AW+1)'(1)) begin
                                push_en       = 1'b1;
                                push_ent.last = 1'b1;
                                txn_inc       = 1'b1;
                                beat_cnt_d    = '0;
                                state_d       = RX_IDLE;
                            end else begin
                                set_ovf = 1'b1;
                            end
                        end
                        default: begin
                            // Illegal cycle type. An open transaction is closed as faulted.
                            set_proto = 1'b1;
                            if (state_q == RX_BURST) begin
                                push_en    = 1'b1;
                                push_ent   = term_ent;
                                txn_inc    = 1'b1;
                                beat_cnt_d = '0;
                                state_d    = RX_DROP;
                            end
                        end
                    endcase
                end
            end
            RX_DROP: begin
                if (live) begin
                    if (ct == CT_DONE) begin
                        beat_cnt_d = '0;
                        state_d    = RX_IDLE;
                    end else if (ct != CT_VALID) begin
                        set_proto = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = RX_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Framing state and beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RX_IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // FIFO pointers. A push and a pop can happen in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en && !full) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_en)           rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // FIFO storage. No reset is needed because the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_en && !full) mem_q[wr_ptr_q[AW-1:0]] <= push_ent;
    end

    // Sticky error flags (a set in the same cycle beats a clear) and the transaction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            proto_q   <= 1'b0;
            txn_cnt_q <= 16'd0;
        end else begin
            if (set_ovf)         ovf_q   <= 1'b1;
            else if (clr_sticky) ovf_q   <= 1'b0;
            if (set_proto)       proto_q <= 1'b1;
            else if (clr_sticky) proto_q <= 1'b0;
            if (txn_inc)         txn_cnt_q <= txn_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_hero_write_rx.sv
// Bench for hero_write_rx. A transaction-level model predicts the FIFO contents
// as a queue, along with the sticky flags and the transaction count.
// The DUT outputs are compared against this model on every falling edge.
`timescale 1ns/1ps
module tb_hero_write_rx;
  localparam int DEPTH     = 4;
  localparam int MAX_BEATS = 5;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [45:0] hero_write = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [35:0] out_wdat;
  logic [6:0]  out_sub;
  logic        out_last;
  logic        out_err;
  logic        clr_sticky = 1'b0;
  logic        ovf_err;
  logic        proto_err;
  logic [15:0] txn_cnt;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  hero_write_rx #(.DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst_n(rst_n), .hero_write(hero_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_wdat(out_wdat),
    .out_sub(out_sub), .out_last(out_last), .out_err(out_err),
    .clr_sticky(clr_sticky), .ovf_err(ovf_err), .proto_err(proto_err),
    .txn_cnt(txn_cnt), .dbg_state_o(dbg_state)
  );

  // ---------------- reference model ----------------
  // Each exp_q entry is {wdat[35:0], sub[6:0], last, err}.
  logic [44:0] exp_q[$];
  bit          m_open;
  bit          m_discard;
  int          m_beats;
  logic        m_ovf;
  logic        m_proto;
  logic [15:0] m_txn;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_open = 0; m_discard = 0; m_beats = 0;
    m_ovf = 1'b0; m_proto = 1'b0; m_txn = 16'd0;
  endtask

  // Predict the effect of the next rising edge.
  task automatic model_step(input logic [45:0] beat, input bit rdy, input bit clr);
    int          free;
    bit          do_pop, do_push, s_ovf, s_proto;
    logic [44:0] ent;
    logic [1:0]  ct;
    free    = DEPTH - exp_q.size();
    do_pop  = (exp_q.size() != 0) && rdy;
    do_push = 0; s_ovf = 0; s_proto = 0;
    ent     = '0;
    ct      = beat[45:44];
    if (beat[0] && ct != 2'd0) begin
      if (m_discard) begin
        if (ct == 2'd2) begin m_discard = 0; m_beats = 0; end
        else if (ct == 2'd3) s_proto = 1;
      end else if (ct == 2'd1) begin
        if (m_beats + 1 == MAX_BEATS && free >= 1) begin
          do_push = 1; ent = {beat[43:1], 2'b11}; s_proto = 1; m_txn++;
          m_open = 0; m_discard = 1; m_beats = 0;
        end else if (free < 2) begin
          if (m_open) begin do_push = 1; ent = 45'b11; m_txn++; end
          s_ovf = 1; m_open = 0; m_discard = 1; m_beats = 0;
        end else begin
          do_push = 1; ent = {beat[43:1], 2'b00}; m_beats++; m_open = 1;
        end
      end else if (ct == 2'd2) begin
        if (free >= 1) begin
          do_push = 1; ent = {beat[43:1], 2'b10}; m_txn++; m_open = 0; m_beats = 0;
        end else s_ovf = 1;
      end else begin
        s_proto = 1;
        if (m_open) begin
          do_push = 1; ent = 45'b11; m_txn++; m_open = 0; m_discard = 1; m_beats = 0;
        end
      end
    end
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(ent);
    m_ovf   = s_ovf   ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_proto = s_proto ? 1'b1 : (clr ? 1'b0 : m_proto);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs();
    logic [44:0] head;
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("out_wdat", 64'(out_wdat), 64'(head[44:9]));
    check("out_sub",  64'(out_sub),  64'(head[8:2]));
    check("out_last", 64'(out_last), 64'(head[1]));
    check("out_err",  64'(out_err),  64'(head[0]));
    check("ovf_err",  64'(ovf_err),  64'(m_ovf));
    check("proto_err", 64'(proto_err), 64'(m_proto));
    check("txn_cnt",  64'(txn_cnt),  64'(m_txn));
  endtask

  // ---------------- driver tasks ----------------
  // Each call starts at a falling edge, checks the current outputs, drives one beat and then advances one clock.
  task automatic drive(input logic [1:0] ct, input logic [35:0] wd, input logic [6:0] sb,
                       input bit en, input bit rdy, input bit clr);
    check_outputs();
    hero_write = {ct, wd, sb, en};
    out_ready  = rdy;
    clr_sticky = clr;
    model_step(hero_write, rdy, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(2'd0, 36'd0, 7'd0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hero_write = '0; out_ready = 1'b0; clr_sticky = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] rnd;
    int          r;
    logic [1:0]  ct;
    model_clear();
    @(negedge clk);
    do_reset();

    // A single-beat transaction is visible at the head one edge after it is sampled.
    drive(2'd2, 36'h9ABCD1234, 7'h55, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Three-beat burst while out_ready toggles.
    drive(2'd1, 36'h111111111, 7'h11, 1'b1, 1'b1, 1'b0);
    drive(2'd1, 36'h222222222, 7'h22, 1'b1, 1'b0, 1'b0);
    drive(2'd2, 36'h333333333, 7'h33, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Overflow with no draining, followed by a DONE that is dropped.
    for (int i = 0; i < 6; i++) drive(2'd1, 36'(i + 'hA0), 7'(i), 1'b1, 1'b0, 1'b0);
    drive(2'd2, 36'hFFF, 7'h7F, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b1);
    drive(2'd0, 36'd0, 7'd0, 1'b0, 1'b1, 1'b1);

    // Over-length transaction.
    for (int i = 0; i < MAX_BEATS + 1; i++) drive(2'd1, 36'(i + 'hB0), 7'(i + 8), 1'b1, 1'b1, 1'b0);
    drive(2'd2, 36'hEEE, 7'h6E, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Protocol errors, a gated beat, and clearing the sticky flags.
    drive(2'd0, 36'd0, 7'd0, 1'b0, 1'b1, 1'b1);
    drive(2'd1, 36'h123456789, 7'h2A, 1'b1, 1'b1, 1'b0);
    drive(2'd3, 36'hDEAD, 7'h15, 1'b1, 1'b1, 1'b0);
    drive(2'd3, 36'hBEEF, 7'h16, 1'b1, 1'b1, 1'b0);
    drive(2'd2, 36'd1, 7'd1, 1'b1, 1'b1, 1'b0);
    drive(2'd1, 36'h5A5A, 7'h5A, 1'b0, 1'b1, 1'b0);
    drive(2'd3, 36'd0, 7'd0, 1'b1, 1'b1, 1'b1);
    drive(2'd0, 36'd0, 7'd0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Reset in the middle of a burst, then a clean single-beat transaction.
    drive(2'd1, 36'h0C0, 7'h0C, 1'b1, 1'b0, 1'b0);
    drive(2'd1, 36'h0C1, 7'h0D, 1'b1, 1'b0, 1'b0);
    do_reset();
    drive(2'd2, 36'h0D0D0D0D0, 7'h3C, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        do_reset();
      end else begin
        r = int'($urandom_range(0, 99));
        ct = (r < 20) ? 2'd0 : (r < 70) ? 2'd1 : (r < 93) ? 2'd2 : 2'd3;
        rnd = {$urandom(), $urandom()};
        drive(ct, rnd[35:0], rnd[42:36], $urandom_range(0, 9) != 0,
              $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0);
      end
    end
    idle(DEPTH + 2, 1'b1);
    check_outputs();

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
